// File: rtl/inst_queue.sv
// Instruction queue between fetch and control: circular buffer of {inst, pc}
// with show-ahead head, occupancy counter, sticky overflow and one-cycle flush.
module inst_queue #(
    parameter int DEPTH    = 4,
    parameter int INST_LEN = 32,
    parameter int AD_LEN   = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       inst_valid_i,
    input  logic [INST_LEN-1:0]        inst_i,
    input  logic [AD_LEN-1:0]          pc_i,
    output logic                       full_o,
    output logic                       inst_valid_o,
    output logic [INST_LEN-1:0]        inst_o,
    output logic [AD_LEN-1:0]          pc_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INST_LEN-1:0] inst_mem_q [DEPTH];
    logic [AD_LEN-1:0]   pc_mem_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic push_s;
    logic pop_s;
    logic mem_we_s;

    // Status depends only on registered occupancy, so full refuses a same-cycle push even when popping.
    assign full_o       = (count_q == CW'(DEPTH));
    assign inst_valid_o = (count_q != {CW{1'b0}});
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign inst_o       = inst_mem_q[rd_ptr_q];
    assign pc_o         = pc_mem_q[rd_ptr_q];

    assign push_s   = inst_valid_i && !full_o;
    assign pop_s    = inst_valid_o && ready_i;
    assign mem_we_s = push_s && !flush_i && !reset_i;

    // Next-state for pointers, occupancy and sticky overflow; flush overrides push and pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (inst_valid_i && full_o) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are left as-is on reset and flush.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            inst_mem_q[wr_ptr_q] <= inst_i;
            pc_mem_q[wr_ptr_q]   <= pc_i;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=4): scoreboard of pushed entries,
// popped and compared when the DUT hands the head to control.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic [31:0] pc_i = 32'h0;
    logic        full_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;

    logic        popped;
    logic [31:0] got_i, got_p, exp_i, exp_p;

    inst_queue #(.DEPTH(DEPTH), .INST_LEN(32), .AD_LEN(32)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .full_o       (full_o),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .ready_i      (ready_i),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected simulation end");
        $fatal(1);
    end

    // Drive one cycle, pop the scoreboard on a handshake, update the model, then step past the edge.
    task automatic cycle(input logic push, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic flush, input logic rst);
        int c0;
        inst_valid_i = push; inst_i = inst; pc_i = pc;
        ready_i = rdy; flush_i = flush; reset_i = rst;
        #1;
        c0 = m_cnt;
        popped = 1'b0;
        if (flush || rst) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            if (rdy && c0 > 0) begin
                popped = 1'b1;
                got_i = inst_o; got_p = pc_o;
                {exp_i, exp_p} = sb.pop_front();
            end
            if (push && c0 < DEPTH) sb.push_back({inst, pc});
            if (push && c0 == DEPTH) m_ovf = 1'b1;
        end
        m_cnt = sb.size();
        @(posedge clk_i);
        #1;
        inst_valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; reset_i = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || full_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d valid=%b full=%b ovf=%b, required 0 0 0 0",
                     count_o, inst_valid_o, full_o, overflow_o);
        end
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 32'h11 * (k + 1), 32'(4 * k), 1'b0, 1'b0, 1'b0);
        checks++;
        if (count_o !== 3'd4 || full_o !== 1'b1) begin
            errors++;
            $display("FAIL fill: count=%0d full=%b, required 4 1", count_o, full_o);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!popped || got_i !== exp_i || got_p !== exp_p || got_i !== 32'h11 * (k + 1)) begin
                errors++;
                $display("FAIL drain[%0d]: got %h/%h, required %h/%h", k, got_i, got_p, exp_i, exp_p);
            end
        end
        checks++;
        if (inst_valid_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL drained: valid=%b count=%0d, required 0 0", inst_valid_o, count_o);
        end
    endtask

    task automatic test_latency();
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_pre: valid=%b, required 0", inst_valid_o);
        end
        cycle(1'b1, 32'hAA, 32'h40, 1'b0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'hAA || pc_o !== 32'h40) begin
            errors++;
            $display("FAIL latency_post: valid=%b inst=%h pc=%h, required 1 000000aa 00000040",
                     inst_valid_o, inst_o, pc_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!popped || got_i !== exp_i || count_o !== 3'(m_cnt)) begin
            errors++;
            $display("FAIL latency_pop: got %h count=%0d, required %h %0d", got_i, count_o, exp_i, m_cnt);
        end
    endtask

    task automatic test_stream();
        cycle(1'b1, 32'h100, 32'h1000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h101, 32'h1004, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k < 12; k++) begin
            cycle(1'b1, 32'h100 + 32'(k), 32'h1000 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
            checks++;
            if (!popped || got_i !== exp_i || got_p !== exp_p || count_o !== 3'd2) begin
                errors++;
                $display("FAIL stream[%0d]: got %h/%h count=%0d, required %h/%h 2",
                         k, got_i, got_p, count_o, exp_i, exp_p);
            end
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!popped || got_i !== exp_i || got_p !== exp_p) begin
                errors++;
                $display("FAIL stream_tail[%0d]: got %h/%h, required %h/%h", k, got_i, got_p, exp_i, exp_p);
            end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 32'hA0 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            cycle(1'b1, 32'h55, 32'h300, 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 3'd4 || inst_o === 32'h55 || overflow_o !== m_ovf) begin
            errors++;
            $display("FAIL overflow: ovf=%b count=%0d head=%h, required 1 4 000000a0", overflow_o, count_o, inst_o);
        end
        cycle(1'b1, 32'h55, 32'h300, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!popped || got_i !== 32'hA0 || count_o !== 3'd3 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got %h count=%0d ovf=%b, required 000000a0 3 1", got_i, count_o, overflow_o);
        end
        for (int k = 1; k < 4; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!popped || got_i !== exp_i || got_i !== 32'hA0 + 32'(k)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: got %h, required %h", k, got_i, 32'hA0 + 32'(k));
            end
        end
        checks++;
        if (inst_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: valid=%b ovf=%b, required 0 1", inst_valid_o, overflow_o);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'hC0 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h99, 32'h500, 1'b1, 1'b1, 1'b0);
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b ovf=%b, required 0 0 0", count_o, inst_valid_o, overflow_o);
        end
        cycle(1'b1, 32'h77, 32'h600, 1'b0, 1'b0, 1'b0);
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h77 || pc_o !== 32'h600 || count_o !== 3'd1) begin
            errors++;
            $display("FAIL post_flush: valid=%b inst=%h pc=%h count=%0d, required 1 00000077 00000600 1",
                     inst_valid_o, inst_o, pc_o, count_o);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'hD0, 32'h700, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count_o !== 3'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: count=%0d, required 2", count_o);
        end
        cycle(1'b1, 32'hD1, 32'h704, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || full_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d valid=%b full=%b ovf=%b, required 0 0 0 0",
                     count_o, inst_valid_o, full_o, overflow_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || popped) begin
            errors++;
            $display("FAIL reset_discard: count=%0d valid=%b, required 0 0", count_o, inst_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_stream();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
